// File: rtl/driver_stream_bridge_mc_if.sv
// Bus and sample-stream signals of the audio-out bridge.
// master = CPU/producer side, slave = bridge side.
interface driver_stream_bridge_mc_if #(
    parameter int DATA_SIZE = 24,
    parameter int NUM_CH    = 2
);
    logic                        chipselect;
    logic [1:0]                  address;
    logic                        read;
    logic                        write;
    logic [31:0]                 write_data;
    logic [31:0]                 read_data;
    logic                        source_valid;
    logic [NUM_CH*DATA_SIZE-1:0] source_data;
    logic                        source_ready;

    modport master (
        output chipselect, address, read, write, write_data, source_valid, source_data,
        input  read_data, source_ready
    );

    modport slave (
        input  chipselect, address, read, write, write_data, source_valid, source_data,
        output read_data, source_ready
    );
endinterface

// File: rtl/driver_stream_bridge_mc.sv
// Multi-channel stream-to-bus bridge: buffers NUM_CH-sample frames in a DEPTH-frame FIFO
// and hands them to the CPU one sample per DATA read, with status/control and interrupt.
module driver_stream_bridge_mc #(
    parameter int DATA_SIZE    = 24,
    parameter int NUM_CH       = 2,
    parameter int DEPTH        = 16,
    parameter int DROP_ON_FULL = 0,
    parameter int LVL_W        = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    driver_stream_bridge_mc_if.slave bus,
    output logic                    irq
);
    localparam int FRAME_W = NUM_CH * DATA_SIZE;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [FRAME_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [CH_W-1:0]      ch_sel;
    logic                 irq_en;
    logic [15:0]          threshold;
    logic                 ovf;
    logic                 udf;
    logic                 full;
    logic                 empty;
    logic                 flush;
    logic                 wr_ctrl;
    logic                 wr_clear;
    logic                 data_rd;
    logic                 pop_word;
    logic                 pop_frame;
    logic                 push;
    logic                 drop;
    logic [DATA_SIZE-1:0] sample;
    logic [31:0]          status_word;
    logic [31:0]          ctrl_word;
    logic                 unused_write_bits;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign bus.source_ready = (DROP_ON_FULL != 0) ? 1'b1 : !full;

    assign wr_ctrl   = bus.chipselect && bus.write && (bus.address == 2'd2);
    assign wr_clear  = bus.chipselect && bus.write && (bus.address == 2'd3);
    assign flush     = wr_ctrl && bus.write_data[1];
    assign data_rd   = bus.chipselect && bus.read && (bus.address == 2'd0);
    assign pop_word  = data_rd && !empty;
    assign pop_frame = pop_word && (ch_sel == CH_W'(NUM_CH - 1));

    // A flush in the same cycle wins over an incoming frame, which is then simply lost.
    assign push = bus.source_valid && !full && !flush;
    assign drop = (DROP_ON_FULL != 0) && bus.source_valid && full && !flush;

    assign status_word = {3'(ch_sel), ovf, udf, irq, full, empty, 8'b0, 16'(level)};
    assign ctrl_word   = {threshold, 14'b0, 1'b0, irq_en};
    assign unused_write_bits = ^bus.write_data[15:2];

    always_comb begin
        sample = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == CH_W'(c)) begin
                sample = mem[rd_ptr][c*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.source_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ch_sel <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ch_sel <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_frame) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (pop_word) begin
                ch_sel <= pop_frame ? '0 : ch_sel + 1'b1;
            end
            if (push && !pop_frame) begin
                level <= level + 1'b1;
            end else if (!push && pop_frame) begin
                level <= level - 1'b1;
            end
        end
    end

    // Sticky flags: a new drop or underflow wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en        <= 1'b0;
            threshold     <= '0;
            ovf           <= 1'b0;
            udf           <= 1'b0;
            bus.read_data <= '0;
            irq           <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en    <= bus.write_data[0];
                threshold <= bus.write_data[31:16];
            end
            if (wr_clear && bus.write_data[0]) begin
                ovf <= 1'b0;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
            if (wr_clear && bus.write_data[1]) begin
                udf <= 1'b0;
            end
            if (data_rd && empty) begin
                udf <= 1'b1;
            end
            if (bus.chipselect && bus.read) begin
                case (bus.address)
                    2'd0:    bus.read_data <= empty ? 32'd0 : 32'(sample);
                    2'd1:    bus.read_data <= status_word;
                    2'd2:    bus.read_data <= ctrl_word;
                    default: bus.read_data <= 32'd0;
                endcase
            end
            irq <= irq_en && (((threshold != 16'd0) && (32'(level) >= 32'(threshold))) || ovf);
        end
    end
endmodule
